// File: rtl/block_spawner_pkg.sv
// block_spawner_pkg: shared types and constants for the falling-block level sequencer
//   spawn_state_e : sequencer states
//   SCREEN_*      : visible screen limits in pixels
//   LFSR_*        : width and tap positions of the spawn-position LFSR (x^10 + x^7 + 1)
package block_spawner_pkg;
   typedef enum logic [2:0] {IDLE, GAP, FALL, CLEAR, DONE} spawn_state_e;
   localparam int SCREEN_X_MAX = 639;
   localparam int SCREEN_Y_MAX = 479;
   localparam int LFSR_W       = 10;
   localparam int LFSR_TAP_HI  = 9;
   localparam int LFSR_TAP_LO  = 6;
endpackage

// File: rtl/block_spawner_if.sv
// block_spawner_if: handshake between the level sequencer and the block/player logic
//   start, Collision, end_level          : towards the sequencer
//   block_ready, block_clear, Block_X_Center,
//   hits, misses, level_done, level_failed : from the sequencer
//   modport slave is taken by the sequencer, master by whoever drives it
interface block_spawner_if;
   logic       start;
   logic       Collision;
   logic       end_level;
   logic       block_ready;
   logic       block_clear;
   logic [9:0] Block_X_Center;
   logic [3:0] hits;
   logic [3:0] misses;
   logic       level_done;
   logic       level_failed;
   modport master (
      output start, Collision, end_level,
      input  block_ready, block_clear, Block_X_Center, hits, misses, level_done, level_failed
   );
   modport slave (
      input  start, Collision, end_level,
      output block_ready, block_clear, Block_X_Center, hits, misses, level_done, level_failed
   );
endinterface

// File: rtl/block_spawner_lfsr.sv
// block_spawner_lfsr: free-running spawn LFSR plus mapping of its value into [X_MIN, X_MAX]
//   frame_clk : frame clock, LFSR steps on every edge
//   Reset     : asynchronous active-low reset, reloads LFSR_SEED
//   cand      : candidate spawn centre derived from the current LFSR value
module block_spawner_lfsr
   import block_spawner_pkg::*;
#(
   parameter int         X_MIN     = 40,
   parameter int         X_MAX     = 600,
   parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
   input  logic       frame_clk,
   input  logic       Reset,
   output logic [9:0] cand
);
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end
   // values above X_MAX fold down by the width of the legal window; values below X_MIN shift up
   always_comb cand = lfsr_q < 10'(X_MIN) ? lfsr_q + 10'(X_MIN)
                    : lfsr_q > 10'(X_MAX) ? lfsr_q - 10'(X_MAX - X_MIN + 1)
                    : lfsr_q;
endmodule

// File: rtl/block_spawner.sv
// block_spawner: level sequencer for the falling block - spawns, scores hits/misses, ends the level
//   frame_clk : frame clock
//   Reset     : asynchronous active-low reset
//   bus       : block_spawner_if.slave (start/Collision/end_level in, block control and score out)
//   Optional BLOCK_SPAWNER_SPEEDUP_EN: each hit shortens the inter-block gap by 4 frames (floor 7).
module block_spawner
   import block_spawner_pkg::*;
#(
   parameter int         NUM_BLOCKS = 8,
   parameter int         GAP_FRAMES = 60,
   parameter int         MAX_MISSES = 3,
   parameter int         X_MIN      = 40,
   parameter int         X_MAX      = 600,
   parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
   input  logic            frame_clk,
   input  logic            Reset,
   block_spawner_if.slave  bus
);
   spawn_state_e state_q, state_d;
   logic [3:0]   hits_q, hits_d, misses_q, misses_d;
   logic [9:0]   x_q, x_d, gap_q, gap_d, gap_load, cand;
   logic         end_q, miss_ev, level_start;

   block_spawner_lfsr #(.X_MIN(X_MIN), .X_MAX(X_MAX), .LFSR_SEED(LFSR_SEED)) u_lfsr (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .cand     (cand)
   );

   assign miss_ev     = bus.end_level & ~end_q;
   assign level_start = (state_q == IDLE || state_q == DONE) && bus.start;

`ifdef BLOCK_SPAWNER_SPEEDUP_EN
   logic [9:0] reload_q, reload_d;
   assign gap_load = reload_q;
   always_comb begin
      reload_d = reload_q;
      if (level_start)
         reload_d = 10'(GAP_FRAMES - 1);
      else if (state_q == FALL && bus.Collision)
         reload_d = reload_q > 10'd10 ? reload_q - 10'd4 : reload_q < 10'd7 ? reload_q : 10'd7;
   end
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) reload_q <= '0;
      else        reload_q <= reload_d;
   end
`else
   assign gap_load = 10'(GAP_FRAMES - 1);
`endif

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         hits_q   <= '0;
         misses_q <= '0;
         x_q      <= 10'(X_MIN);
         gap_q    <= '0;
         end_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
         x_q      <= x_d;
         gap_q    <= gap_d;
         end_q    <= bus.end_level;
      end
   end

   always_comb begin
      state_d  = state_q;
      hits_d   = hits_q;
      misses_d = misses_q;
      x_d      = x_q;
      gap_d    = gap_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = GAP;
               hits_d   = '0;
               misses_d = '0;
               gap_d    = 10'(GAP_FRAMES - 1);
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = FALL;
               x_d     = cand;
            end else gap_d = gap_q - 10'd1;
         end
         FALL: begin
            // a catch wins over a simultaneous fall-through
            if (bus.Collision) begin
               hits_d  = hits_q + 4'd1;
               state_d = CLEAR;
            end else if (miss_ev) begin
               misses_d = misses_q + 4'd1;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            if (misses_q == 4'(MAX_MISSES) || hits_q + misses_q == 4'(NUM_BLOCKS)) state_d = DONE;
            else begin
               state_d = GAP;
               gap_d   = gap_load;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // decoded straight from state so block_ready falls with the asynchronous reset
   always_comb begin
      bus.block_ready    = state_q == FALL;
      bus.block_clear    = state_q == CLEAR;
      bus.level_done     = state_q == DONE;
      bus.level_failed   = state_q == DONE && misses_q == 4'(MAX_MISSES);
      bus.Block_X_Center = x_q;
      bus.hits           = hits_q;
      bus.misses         = misses_q;
   end
endmodule

// File: tb/tb_block_spawner.sv
// tb_block_spawner: directed self-checking bench for block_spawner with default parameters
module tb_block_spawner;
   logic       frame_clk = 1'b0;
   logic       Reset     = 1'b0;
   int         n_chk     = 0;
   int         n_fail    = 0;
   logic [9:0] m_lfsr, m_x;

   block_spawner_if bus();

   block_spawner dut (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .bus      (bus)
   );

   always #5 frame_clk = ~frame_clk;

   // reference spawn position: x^10+x^7+1 LFSR from 0x2A5, window [40,600], fold width 561
   function automatic logic [9:0] map_x(input logic [9:0] v);
      return v < 10'd40 ? v + 10'd40 : v > 10'd600 ? v - 10'd561 : v;
   endfunction

   always @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         m_lfsr <= 10'h2A5;
         m_x    <= 10'd40;
      end else begin
         m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
         m_x    <= map_x(m_lfsr);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge frame_clk);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!bus.block_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      if (!bus.block_ready) cyc = -1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      tick(2);
      n_chk++;
      if (bus.Block_X_Center !== 10'd40) begin
         n_fail++;
         $display("FAIL reset_x: got %0d want 40", bus.Block_X_Center);
      end
      n_chk++;
      if ({bus.block_ready, bus.block_clear, bus.hits, bus.misses, bus.level_done, bus.level_failed} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b clear=%b hits=%0d misses=%0d done=%b failed=%b want all 0",
                  bus.block_ready, bus.block_clear, bus.hits, bus.misses, bus.level_done, bus.level_failed);
      end
      Reset = 1'b1;
   endtask

   task automatic test_first_drop();
      int cyc;
      logic [9:0] ex;
      pulse_start();
      tick(10);
      pulse_start();
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 49) begin
         n_fail++;
         $display("FAIL first_drop_latency: got %0d want 49", cyc);
      end
      ex = m_x;
      n_chk++;
      if (bus.Block_X_Center !== ex) begin
         n_fail++;
         $display("FAIL first_drop_x: got %0d want %0d", bus.Block_X_Center, ex);
      end
      n_chk++;
      if ((bus.Block_X_Center >= 10'd40 && bus.Block_X_Center <= 10'd600) !== 1'b1) begin
         n_fail++;
         $display("FAIL first_drop_x_range: got %0d want 40..600", bus.Block_X_Center);
      end
      repeat (5) begin
         tick();
         n_chk++;
         if ({bus.block_ready, bus.Block_X_Center} !== {1'b1, ex}) begin
            n_fail++;
            $display("FAIL x_stable: got ready=%b x=%0d want ready=1 x=%0d", bus.block_ready, bus.Block_X_Center, ex);
         end
      end
   endtask

   task automatic test_hit();
      int cyc;
      bus.Collision = 1'b1;
      tick();
      bus.Collision = 1'b0;
      n_chk++;
      if ({bus.block_clear, bus.block_ready, bus.hits, bus.misses} !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
         n_fail++;
         $display("FAIL hit_clear: got clear=%b ready=%b hits=%0d misses=%0d want 1 0 1 0",
                  bus.block_clear, bus.block_ready, bus.hits, bus.misses);
      end
      tick();
      n_chk++;
      if (bus.block_clear !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_clear_one_frame: got %b want 0", bus.block_clear);
      end
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 60) begin
         n_fail++;
         $display("FAIL hit_regap_latency: got %0d want 60", cyc);
      end
      n_chk++;
      if (bus.Block_X_Center !== m_x) begin
         n_fail++;
         $display("FAIL hit_new_x: got %0d want %0d", bus.Block_X_Center, m_x);
      end
   endtask

   task automatic test_miss_hold();
      int cyc;
      int clears = 0;
      bus.end_level = 1'b1;
      repeat (5) begin
         tick();
         if (bus.block_clear) clears++;
      end
      bus.end_level = 1'b0;
      repeat (3) begin
         tick();
         if (bus.block_clear) clears++;
      end
      n_chk++;
      if ({bus.hits, bus.misses} !== {4'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL miss_count: got hits=%0d misses=%0d want 1 1", bus.hits, bus.misses);
      end
      n_chk++;
      if (clears !== 1) begin
         n_fail++;
         $display("FAIL miss_clear_pulses: got %0d want 1", clears);
      end
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 54) begin
         n_fail++;
         $display("FAIL miss_regap_latency: got %0d want 54", cyc);
      end
      n_chk++;
      if (bus.Block_X_Center !== m_x) begin
         n_fail++;
         $display("FAIL miss_new_x: got %0d want %0d", bus.Block_X_Center, m_x);
      end
   endtask

   task automatic test_both();
      bus.Collision = 1'b1;
      bus.end_level = 1'b1;
      tick();
      bus.Collision = 1'b0;
      bus.end_level = 1'b0;
      n_chk++;
      if ({bus.block_clear, bus.hits, bus.misses} !== {1'b1, 4'd2, 4'd1}) begin
         n_fail++;
         $display("FAIL both_hit_wins: got clear=%b hits=%0d misses=%0d want 1 2 1",
                  bus.block_clear, bus.hits, bus.misses);
      end
   endtask

   task automatic test_fail();
      int cyc;
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         wait_ready(cyc);
         n_chk++;
         if (cyc !== 60) begin
            n_fail++;
            $display("FAIL fail_drop_latency[%0d]: got %0d want 60", i, cyc);
         end
         bus.end_level = 1'b1;
         tick();
         bus.end_level = 1'b0;
         n_chk++;
         if ({bus.block_clear, bus.misses} !== {1'b1, 4'(i + 1)}) begin
            n_fail++;
            $display("FAIL fail_miss[%0d]: got clear=%b misses=%0d want 1 %0d", i, bus.block_clear, bus.misses, i + 1);
         end
         tick();
         n_chk++;
         if (bus.level_done !== (i == 2)) begin
            n_fail++;
            $display("FAIL fail_done[%0d]: got %b want %b", i, bus.level_done, i == 2);
         end
      end
      tick(3);
      n_chk++;
      if ({bus.level_done, bus.level_failed, bus.block_ready, bus.misses} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin
         n_fail++;
         $display("FAIL fail_done_state: got done=%b failed=%b ready=%b misses=%0d want 1 1 0 3",
                  bus.level_done, bus.level_failed, bus.block_ready, bus.misses);
      end
      pulse_start();
      n_chk++;
      if ({bus.level_done, bus.level_failed, bus.hits, bus.misses} !== 10'd0) begin
         n_fail++;
         $display("FAIL restart_clear: got done=%b failed=%b hits=%0d misses=%0d want all 0",
                  bus.level_done, bus.level_failed, bus.hits, bus.misses);
      end
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 60) begin
         n_fail++;
         $display("FAIL restart_latency: got %0d want 60", cyc);
      end
   endtask

   task automatic test_success();
      int cyc;
      for (int i = 0; i < 8; i++) begin
         wait_ready(cyc);
         n_chk++;
         if (cyc !== (i == 0 ? 0 : 60)) begin
            n_fail++;
            $display("FAIL success_latency[%0d]: got %0d want %0d", i, cyc, i == 0 ? 0 : 60);
         end
         bus.Collision = 1'b1;
         tick();
         bus.Collision = 1'b0;
         n_chk++;
         if (bus.hits !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL success_hits[%0d]: got %0d want %0d", i, bus.hits, i + 1);
         end
         tick();
      end
      n_chk++;
      if ({bus.level_done, bus.level_failed, bus.block_ready, bus.hits, bus.misses} !== {1'b1, 1'b0, 1'b0, 4'd8, 4'd0}) begin
         n_fail++;
         $display("FAIL success_done: got done=%b failed=%b ready=%b hits=%0d misses=%0d want 1 0 0 8 0",
                  bus.level_done, bus.level_failed, bus.block_ready, bus.hits, bus.misses);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      pulse_start();
      wait_ready(cyc);
      bus.Collision = 1'b1;
      tick();
      bus.Collision = 1'b0;
      tick();
      wait_ready(cyc);
      n_chk++;
      if ({bus.block_ready, bus.hits} !== {1'b1, 4'd1}) begin
         n_fail++;
         $display("FAIL mid_precondition: got ready=%b hits=%0d want 1 1", bus.block_ready, bus.hits);
      end
      #2 Reset = 1'b0;
      #1;
      n_chk++;
      if ({bus.block_ready, bus.block_clear, bus.Block_X_Center, bus.hits, bus.misses, bus.level_done, bus.level_failed}
          !== {1'b0, 1'b0, 10'd40, 4'd0, 4'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset: got ready=%b clear=%b x=%0d hits=%0d misses=%0d done=%b failed=%b want 0 0 40 0 0 0 0",
                  bus.block_ready, bus.block_clear, bus.Block_X_Center, bus.hits, bus.misses, bus.level_done, bus.level_failed);
      end
      tick(2);
      Reset = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.start     = 1'b0;
      bus.Collision = 1'b0;
      bus.end_level = 1'b0;
      test_reset();
      test_first_drop();
      test_hit();
      test_miss_hold();
      test_both();
      test_fail();
      test_success();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
